// File: rtl/mem_lipo_wr_ctrl_pkg.sv
// Shared definitions for the LIPO pixel-buffer port-A writer.
//   - FSM state encoding (3 bits)
//   - Per-phase beat counts
//   - Line-address region selects (luma / chroma)
// PIXEL_WIDTH falls back to 8 bits per pixel when not supplied by the build.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package mem_lipo_wr_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle = 3'd0,
        StLuma = 3'd1,
        StChrU = 3'd2,
        StChrV = 3'd3,
        StDone = 3'd4
    } state_e;

    localparam int unsigned LUMA_LINES = 128;
    localparam int unsigned CHR_LINES  = 32;

    localparam logic [1:0] SEL_LUMA = 2'b00;
    localparam logic [1:0] SEL_CHR  = 2'b01;

endpackage

// File: rtl/mem_lipo_wr_addr_gen.sv
// Line-address generator for the LIPO port-A writer.
// Pure combinational mapping (state, row counter, half bit) -> buffer line address.
//   state_i : current writer FSM state
//   cnt_i   : row counter
//   h_i     : half select within a luma row (0 = left, 1 = right)
//   addr_o  : AW-bit buffer line address
// Chroma mappings exist only when MEM_LIPO_WR_CHROMA_EN is defined.

module mem_lipo_wr_addr_gen
    import mem_lipo_wr_ctrl_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic [STATE_W-1:0] state_i,
    input  logic [5:0]         cnt_i,
    input  logic               h_i,
    output logic [AW-1:0]      addr_o
);

    logic [7:0] line;

    always_comb begin
        line = '0;
        unique case (state_i)
            StLuma: line = {SEL_LUMA, cnt_i[5], h_i, cnt_i[4:0]};
`ifdef MEM_LIPO_WR_CHROMA_EN
            StChrU: line = {SEL_CHR, 1'b0, 1'b0, cnt_i[4:0]};
            StChrV: line = {SEL_CHR, 1'b0, 1'b1, cnt_i[4:0]};
`endif
            default: line = '0;
        endcase
        addr_o = AW'(line);
    end

endmodule

// File: rtl/mem_lipo_wr_ctrl.sv
// Port-A writer engine for the 1-port line-in/parallel-out pixel buffer.
// Loads one LCU (luma, then optionally chroma U and V) as 32-pixel line beats and
// turns each accepted beat into a registered buffer write one cycle later.
// Writes are scheduled around port-B reads: a read request blocks acceptance, so
// the write that would have followed never lines up with the read enable.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : pulse to begin loading an LCU (ignored unless idle)
//   busy_o      : high from accepted start until done_o
//   done_o      : one-cycle pulse after the last line write
//   in_valid_i  : upstream beat valid
//   in_ready_o  : beat can be accepted this cycle (combinational)
//   in_data_i   : 32 pixels, leftmost in the MSBs
//   rd_req_i    : reader will assert its read enable next cycle
//   a_wen_o     : buffer write enable
//   a_addr_o    : buffer line address
//   a_wdata_o   : buffer line data
//
// Build option: MEM_LIPO_WR_CHROMA_EN adds the chroma U/V phases (192 writes per LCU);
// without it the load is luma only (128 writes per LCU).

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module mem_lipo_wr_ctrl
    import mem_lipo_wr_ctrl_pkg::*;
#(
    parameter int unsigned PIX_W = `PIXEL_WIDTH,
    parameter int unsigned AW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [PIX_W*32-1:0] in_data_i,
    input  logic                rd_req_i,
    output logic                a_wen_o,
    output logic [AW-1:0]       a_addr_o,
    output logic [PIX_W*32-1:0] a_wdata_o
);

    localparam int unsigned LW = PIX_W * 32;

    state_e        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          h_q, h_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] wdata_q, wdata_d;

    logic          loading;
    logic          accept;
    logic          last_beat;
    logic [AW-1:0] cur_addr;

    mem_lipo_wr_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .state_i (state_q),
        .cnt_i   (cnt_q),
        .h_i     (h_q),
        .addr_o  (cur_addr)
    );

`ifdef MEM_LIPO_WR_CHROMA_EN
    assign loading = (state_q == StLuma) || (state_q == StChrU) || (state_q == StChrV);
`else
    assign loading = (state_q == StLuma);
`endif

    // A pending read owns the buffer next cycle, so hold off this cycle's beat.
    assign in_ready_o = loading & ~rd_req_i;
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        last_beat = 1'b0;
        unique case (state_q)
            StLuma: last_beat = ({cnt_q, h_q} == 7'(LUMA_LINES - 1));
`ifdef MEM_LIPO_WR_CHROMA_EN
            StChrU,
            StChrV: last_beat = (cnt_q == 6'(CHR_LINES - 1));
`endif
            default: last_beat = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StLuma;
            end
            StLuma: begin
                if (accept) begin
                    if (last_beat) begin
`ifdef MEM_LIPO_WR_CHROMA_EN
                        state_d = StChrU;
`else
                        state_d = StDone;
`endif
                    end else begin
                        // h is the fast bit: left half, right half, next row.
                        {cnt_d, h_d} = {cnt_q, h_q} + 7'd1;
                    end
                end
            end
`ifdef MEM_LIPO_WR_CHROMA_EN
            StChrU: begin
                if (accept) begin
                    if (last_beat) state_d = StChrV;
                    else           cnt_d   = cnt_q + 6'd1;
                end
            end
            StChrV: begin
                if (accept) begin
                    if (last_beat) state_d = StDone;
                    else           cnt_d   = cnt_q + 6'd1;
                end
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Every phase starts from row 0.
        if (state_d != state_q) begin
            cnt_d = '0;
            h_d   = 1'b0;
        end
    end

    always_comb begin
        wen_d   = accept;
        addr_d  = accept ? cur_addr : addr_q;
        wdata_d = accept ? in_data_i : wdata_q;
        done_d  = (state_q == StDone);
        // done_q marks the done pulse; busy drops on the cycle after it.
        busy_d  = ((state_q == StIdle) & start_i) | (busy_q & ~done_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            h_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign a_wen_o   = wen_q;
    assign a_addr_o  = addr_q;
    assign a_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_lipo_wr_ctrl.sv
// Bench for mem_lipo_wr_ctrl: scenario table of full loads (plain, reader stall,
// upstream bubbles, stray start pulse, stall on the last beat) plus a hand-written
// mid-load reset followed by a restart. Accepted beats are queued with their
// expected address/data and popped as a_wen_o appears.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_mem_lipo_wr_ctrl;

    localparam int unsigned PIX_W = `PIXEL_WIDTH;
    localparam int unsigned LW    = PIX_W * 32;
    localparam int unsigned AW    = 8;
`ifdef MEM_LIPO_WR_CHROMA_EN
    localparam int TOTAL = 192;
`else
    localparam int TOTAL = 128;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [LW-1:0] in_data_i = '0;
    logic          rd_req_i = 1'b0;
    logic          a_wen_o;
    logic [AW-1:0] a_addr_o;
    logic [LW-1:0] a_wdata_o;

    mem_lipo_wr_ctrl #(
        .PIX_W (PIX_W),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .rd_req_i   (rd_req_i),
        .a_wen_o    (a_wen_o),
        .a_addr_o   (a_addr_o),
        .a_wdata_o  (a_wdata_o)
    );

    always #5 clk = ~clk;

    // Scenario record: stimulus knobs plus the expected cycle of done_o,
    // counted in cycles after the start_i edge.
    typedef struct {
        int stall_at;
        int stall_len;
        int bubble;
        int start_at;
        int exp_done;
    } scen_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wr_t;

    wr_t   sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    run_id   = 0;
    scen_t scen[5];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL run%0d %s: got %0h expected %0h", run_id, name, act, exp);
        end
    endtask

    // Luma: row = k/2, half = k%2; rows 32..63 live 0x40 above rows 0..31.
    // Chroma U then V are contiguous from 0x80.
    function automatic logic [AW-1:0] exp_addr(input int k);
        if (k < 128) return AW'((k / 64) * 64 + (k % 2) * 32 + (k / 2) % 32);
        return AW'(8'h80 + (k - 128));
    endfunction

    function automatic logic [LW-1:0] data_of(input int k);
        logic [LW-1:0] d;
        d = '0;
        for (int i = 0; i < int'(LW / 32); i++) begin
            d[i*32 +: 32] = 32'(k) * 32'h9E3779B1 + 32'(i) + 32'(run_id << 24);
        end
        return d;
    endfunction

    task automatic run_load(input scen_t s, input bit do_reset);
        int  k          = 0;
        int  writes     = 0;
        int  stall_left = s.stall_len;
        bit  pend       = 1'b0;
        bit  start_sent = 1'b0;
        wr_t e;
        run_id++;
        if (do_reset) begin
            @(negedge clk);
            rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; rd_req_i = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            in_valid_i = 1'b1;
            in_data_i  = data_of(0);
            #1;
            check("rst_wen", a_wen_o, 0);
            check("rst_addr", a_addr_o, 0);
            check("rst_wdata", a_wdata_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_ready", in_ready_o, 0);
        end else begin
            @(negedge clk);
            in_valid_i = 1'b1;
            in_data_i  = data_of(0);
            #1;
            check("idle_ready", in_ready_o, 0);
        end
        // Start cycle: still idle, the presented beat must not be taken.
        @(negedge clk);
        start_i = 1'b1;
        #1;
        check("start_ready", in_ready_o, 0);

        for (int c = 1; c <= s.exp_done + 1; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            check("wen", a_wen_o, pend);
            if (a_wen_o) begin
                writes++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("addr", a_addr_o, e.addr);
                    check("wdata", a_wdata_o, e.data);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL run%0d wen_unexpected: got write to %0h expected none", run_id,
                             a_addr_o);
                end
`ifndef MEM_LIPO_WR_CHROMA_EN
                check("luma_only_addr", a_addr_o < 8'h80, 1);
`endif
            end
            check("done", done_o, c == s.exp_done);
            if (c == 1) check("busy_set", busy_o, 1);
            if (c == s.exp_done) begin
                check("busy_at_done", busy_o, 1);
                check("writes_at_done", writes, TOTAL);
            end
            if (c == s.exp_done + 1) check("busy_clear", busy_o, 0);

            in_valid_i = (s.bubble != 0) ? (c % 2 == 1) : 1'b1;
            rd_req_i   = (k == s.stall_at) && (stall_left > 0);
            if (rd_req_i) stall_left--;
            if (s.start_at >= 0 && k == s.start_at && !start_sent) begin
                start_i    = 1'b1;
                start_sent = 1'b1;
            end
            in_data_i = data_of(k);
            #1;
            if (rd_req_i) check("ready_in_stall", in_ready_o, 0);
            pend = in_valid_i & in_ready_o;
            if (pend) begin
                sb.push_back('{addr: exp_addr(k), data: data_of(k)});
                k++;
            end
        end
        in_valid_i = 1'b0;
        rd_req_i   = 1'b0;
        start_i    = 1'b0;
        check("total_writes", writes, TOTAL);
        check("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int k;
        scen[0] = '{stall_at: -1,        stall_len: 0, bubble: 0, start_at: -1,
                    exp_done: TOTAL + 2};
        scen[1] = '{stall_at: 40,        stall_len: 3, bubble: 0, start_at: -1,
                    exp_done: TOTAL + 5};
        scen[2] = '{stall_at: -1,        stall_len: 0, bubble: 1, start_at: -1,
                    exp_done: 2 * TOTAL + 1};
        scen[3] = '{stall_at: -1,        stall_len: 0, bubble: 0, start_at: 10,
                    exp_done: TOTAL + 2};
        scen[4] = '{stall_at: TOTAL - 1, stall_len: 2, bubble: 0, start_at: -1,
                    exp_done: TOTAL + 4};

        for (int i = 0; i < 5; i++) run_load(scen[i], 1'b1);

        // Reset in the middle of a luma load, then restart without another reset.
        run_id++;
        @(negedge clk);
        start_i    = 1'b1;
        in_valid_i = 1'b1;
        k = 0;
        for (int c = 0; c < 300 && k < 71; c++) begin
            @(negedge clk);
            start_i   = 1'b0;
            in_data_i = data_of(k);
            #1;
            if (in_ready_o) k++;
        end
        check("midrst_beats", k, 71);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_wen", a_wen_o, 0);
        check("midrst_addr", a_addr_o, 0);
        check("midrst_wdata", a_wdata_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_ready", in_ready_o, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_done", done_o, 0);
            check("midrst_no_wen", a_wen_o, 0);
        end
        in_valid_i = 1'b0;
        run_load(scen[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
